// File: rtl/i2c_target.sv
// I2C target: filtered SCL/SDA, START/STOP detect, 7-bit address match, byte strobes out/in.
// Latency: sync 2 + filter FILT+1 clk to events, outputs registered; backpressure: SCL stretched until tx_stb.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50,
    parameter int         FILT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_stb,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_stb,
    output logic       start_stb,
    output logic       stop_stb,
    output logic       busy
);
    localparam int CW = (FILT < 1) ? 1 : $clog2(FILT + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR_S, ADDR_ACK, WR_DATA, WR_ACK,
        RD_WAIT, RD_HOLD, RD_DATA, RD_ACK, IGNORE
    } state_t;

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_f, sda_f, scl_d, sda_d;
    logic [CW-1:0] scl_cnt, sda_cnt;
    logic          scl_rise, scl_fall, sda_rise, sda_fall, start_ev, stop_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_f;
            sda_d    <= sda_f;
            // A filtered line flips on the FILT+1-th consecutive differing sample.
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CW'(FILT)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CW'(FILT)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign sda_rise = sda_f & ~sda_d;
    assign sda_fall = ~sda_f & sda_d;
    assign start_ev = sda_fall & scl_f;
    assign stop_ev  = sda_rise & scl_f;

    state_t     state, state_n;
    logic [3:0] bit_cnt, cnt_n;
    logic [7:0] shreg, sh_n, rx_data_n;
    logic       rw, rw_n, first, first_n;
    logic       sda_oe_n, scl_oe_n, tx_req_n, busy_n, rx_stb_n, rx_first_n, start_n, stop_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            first     <= 1'b0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= '0;
            rx_stb    <= 1'b0;
            rx_first  <= 1'b0;
            start_stb <= 1'b0;
            stop_stb  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= cnt_n;
            shreg     <= sh_n;
            rw        <= rw_n;
            first     <= first_n;
            sda_oe    <= sda_oe_n;
            scl_oe    <= scl_oe_n;
            tx_req    <= tx_req_n;
            busy      <= busy_n;
            rx_data   <= rx_data_n;
            rx_stb    <= rx_stb_n;
            rx_first  <= rx_first_n;
            start_stb <= start_n;
            stop_stb  <= stop_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = bit_cnt;
        sh_n       = shreg;
        rw_n       = rw;
        first_n    = first;
        sda_oe_n   = sda_oe;
        scl_oe_n   = scl_oe;
        tx_req_n   = tx_req;
        busy_n     = busy;
        rx_data_n  = rx_data;
        rx_stb_n   = 1'b0;
        rx_first_n = 1'b0;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        if (start_ev || stop_ev) begin
            sda_oe_n = 1'b0;
            scl_oe_n = 1'b0;
            tx_req_n = 1'b0;
            busy_n   = 1'b0;
            start_n  = start_ev;
            stop_n   = stop_ev;
            cnt_n    = '0;
            state_n  = start_ev ? ADDR_S : IDLE;
        end else begin
            case (state)
                ADDR_S, WR_DATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        sh_n  = {shreg[6:0], sda_f};
                        cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (state == WR_DATA) begin
                            rx_stb_n   = 1'b1;
                            rx_data_n  = shreg;
                            rx_first_n = first;
                            first_n    = 1'b0;
                            sda_oe_n   = 1'b1;
                            state_n    = WR_ACK;
                        end else if (shreg[7:1] == ADDR) begin
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                            rw_n     = shreg[0];
                            state_n  = ADDR_ACK;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = '0;
                        if (state == ADDR_ACK && rw) begin
                            scl_oe_n = 1'b1;
                            tx_req_n = 1'b1;
                            state_n  = RD_WAIT;
                        end else begin
                            first_n = (state == ADDR_ACK);
                            state_n = WR_DATA;
                        end
                    end
                end
                RD_WAIT: begin
                    if (tx_stb && tx_req) begin
                        sh_n     = tx_data;
                        sda_oe_n = ~tx_data[7];
                        tx_req_n = 1'b0;
                        cnt_n    = 4'd1;
                        state_n  = RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    scl_oe_n = 1'b0;
                    state_n  = RD_DATA;
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            cnt_n    = '0;
                            state_n  = RD_ACK;
                        end else begin
                            sda_oe_n = ~shreg[6];
                            sh_n     = {shreg[6:0], 1'b0};
                            cnt_n    = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    // bit_cnt=1 records that the host ACKed this byte.
                    if (scl_rise) begin
                        if (sda_f) begin
                            busy_n  = 1'b0;
                            state_n = IGNORE;
                        end else begin
                            cnt_n = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        scl_oe_n = 1'b1;
                        tx_req_n = 1'b1;
                        state_n  = RD_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
